// File: rtl/crc_seq_ctrl.sv
// Bit-serial CRC sequencer: latches a per-message CRC configuration, shifts message
// bytes through the CRC register one bit per clock, then reflects/XORs and presents the result.

module crc_reflect #(
  parameter int MAX_BITS      = 32,
  parameter int MAX_BIT_COUNT = 5
) (
  input  logic [MAX_BITS-1:0]      data_in,
  input  logic [MAX_BIT_COUNT-1:0] bitwidth,
  output logic [MAX_BITS-1:0]      data_out
);
  // Mirror bits 0..bitwidth about their centre; everything above the width reads zero.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BITS; gi++) begin : g_bit
      localparam logic [MAX_BIT_COUNT-1:0] POS = MAX_BIT_COUNT'(gi);
      logic [MAX_BIT_COUNT-1:0] src_idx;
      assign src_idx      = bitwidth - POS;
      assign data_out[gi] = (POS <= bitwidth) ? data_in[src_idx] : 1'b0;
    end
  endgenerate
endmodule

module crc_seq_ctrl #(
  parameter int MAX_BITS      = 32,
  parameter int MAX_BIT_COUNT = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [MAX_BIT_COUNT-1:0] cfg_width_m1,
  input  logic [MAX_BITS-1:0]      cfg_poly,
  input  logic [MAX_BITS-1:0]      cfg_init,
  input  logic                     cfg_refin,
  input  logic                     cfg_refout,
  input  logic [MAX_BITS-1:0]      cfg_xorout,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     crc_valid,
  input  logic                     crc_ready,
  output logic [MAX_BITS-1:0]      crc_out,
  output logic                     busy
);
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, FINAL, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [MAX_BIT_COUNT-1:0]   width_m1_reg, width_m1_next;
  logic [MAX_BITS-1:0]        poly_reg, poly_next;
  logic [MAX_BITS-1:0]        xorout_reg, xorout_next;
  logic                       refin_reg, refin_next;
  logic                       refout_reg, refout_next;
  logic [MAX_BITS-1:0]        crc_reg, crc_next;
  logic [MAX_BITS-1:0]        crc_out_reg, crc_out_next;
  logic [7:0]                 byte_reg, byte_next;
  logic                       last_reg, last_next;
  logic [2:0]                 bit_cnt_reg, bit_cnt_next;

  logic [MAX_BITS-1:0]        mask_in, mask_cur, refl_out;
  logic                       shift_bit, fb;

  function automatic logic [MAX_BITS-1:0] width_mask(input logic [MAX_BIT_COUNT-1:0] w);
    return {MAX_BITS{1'b1}} >> (MAX_BIT_COUNT'(MAX_BITS - 1) - w);
  endfunction

  assign mask_in   = width_mask(cfg_width_m1);
  assign mask_cur  = width_mask(width_m1_reg);
  assign shift_bit = refin_reg ? byte_reg[bit_cnt_reg] : byte_reg[3'd7 - bit_cnt_reg];
  assign fb        = crc_reg[width_m1_reg] ^ shift_bit;

  crc_reflect #(.MAX_BITS(MAX_BITS), .MAX_BIT_COUNT(MAX_BIT_COUNT)) u_reflect (
    .data_in  (crc_reg),
    .bitwidth (width_m1_reg),
    .data_out (refl_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      width_m1_reg <= '0;
      poly_reg     <= '0;
      xorout_reg   <= '0;
      refin_reg    <= 1'b0;
      refout_reg   <= 1'b0;
      crc_reg      <= '0;
      crc_out_reg  <= '0;
      byte_reg     <= '0;
      last_reg     <= 1'b0;
      bit_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      width_m1_reg <= width_m1_next;
      poly_reg     <= poly_next;
      xorout_reg   <= xorout_next;
      refin_reg    <= refin_next;
      refout_reg   <= refout_next;
      crc_reg      <= crc_next;
      crc_out_reg  <= crc_out_next;
      byte_reg     <= byte_next;
      last_reg     <= last_next;
      bit_cnt_reg  <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    width_m1_next = width_m1_reg;
    poly_next     = poly_reg;
    xorout_next   = xorout_reg;
    refin_next    = refin_reg;
    refout_next   = refout_reg;
    crc_next      = crc_reg;
    crc_out_next  = crc_out_reg;
    byte_next     = byte_reg;
    last_next     = last_reg;
    bit_cnt_next  = bit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // Poly and xorout are pre-masked so the datapath never sees bits above width.
          width_m1_next = cfg_width_m1;
          poly_next     = cfg_poly & mask_in;
          xorout_next   = cfg_xorout & mask_in;
          refin_next    = cfg_refin;
          refout_next   = cfg_refout;
          crc_next      = cfg_init & mask_in;
          state_next    = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (in_valid) begin
          byte_next    = in_data;
          last_next    = in_last;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        crc_next     = ((crc_reg << 1) & mask_cur) ^ (fb ? poly_reg : '0);
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = last_reg ? FINAL : WAIT_BYTE;
      end
      FINAL: begin
        crc_out_next = (refout_reg ? refl_out : crc_reg) ^ xorout_reg;
        state_next   = DONE;
      end
      DONE: begin
        if (crc_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == WAIT_BYTE);
  assign crc_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign crc_out   = crc_out_reg;
endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Directed bench for crc_seq_ctrl: catalogue CRCs over "123456789", handshake timing,
// back-to-back messages, mid-message reset and protocol corner cases.
module tb_crc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, cfg_refin, cfg_refout;
  logic [4:0]  cfg_width_m1;
  logic [31:0] cfg_poly, cfg_init, cfg_xorout;
  logic        in_valid, in_last, in_ready, crc_valid, crc_ready, busy;
  logic [7:0]  in_data;
  logic [31:0] crc_out;

  int tests_run = 0;
  int fails     = 0;
  int lat;
  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_width_m1(cfg_width_m1),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_refin(cfg_refin),
    .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] w, input logic [31:0] p, input logic [31:0] init,
                          input logic ri, input logic ro, input logic [31:0] xo);
    cfg_width_m1 = w; cfg_poly = p; cfg_init = init;
    cfg_refin = ri; cfg_refout = ro; cfg_xorout = xo;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_ready", {31'b0, in_ready}, 32'd1);
    check("start_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap, input logic scramble);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    while (!in_ready && n < 100) begin
      if (scramble) begin
        cfg_width_m1 = 5'($urandom); cfg_poly = $urandom; cfg_init = $urandom;
        cfg_refin = 1'($urandom); cfg_refout = 1'($urandom); cfg_xorout = $urandom;
        start = 1'b1;
      end
      step();
      n++;
    end
    if (n >= 100) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  task automatic send_msg(input int gap_max, input logic scramble);
    for (int i = 0; i < 9; i++)
      send_byte(msg[i], (i == 8), $urandom_range(0, gap_max), scramble);
  endtask

  task automatic wait_crc(output int cycles);
    cycles = 0;
    while (!crc_valid && cycles < 100) begin
      step();
      cycles++;
    end
    check("crc_valid_rise", {31'b0, crc_valid}, 32'd1);
  endtask

  // Checks the result, optionally stalls the consumer (poking start meanwhile), then accepts.
  task automatic take_crc(input string tag, input logic [31:0] exp, input int hold);
    check(tag, crc_out, exp);
    crc_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      step();
      check({tag, "_hold_value"}, crc_out, exp);
      check({tag, "_hold_valid"}, {31'b0, crc_valid}, 32'd1);
    end
    start = 1'b0;
    crc_ready = 1'b1;
    step();
    crc_ready = 1'b0;
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'b0, crc_valid}, 32'd0);
    $display("[TB] %s: crc_out=0x%08h expected=0x%08h", tag, crc_out, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_width_m1 = '0; cfg_poly = '0; cfg_init = '0;
    cfg_refin = 1'b0; cfg_refout = 1'b0; cfg_xorout = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; crc_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_crc_valid", {31'b0, crc_valid}, 32'd0);
    check("rst_crc_out", crc_out, 32'd0);
    rst_n = 1'b1;
    step();

    // CRC-8 with latency measurement on the last byte
    do_start(5'd7, 32'h07, 32'h0, 1'b0, 1'b0, 32'h0);
    send_msg(0, 1'b0);
    wait_crc(lat);
    check("crc8_latency", 32'(lat), 32'd9);
    take_crc("crc8", 32'h000000F4, 0);

    // CRC-16/CCITT-FALSE
    do_start(5'd15, 32'h1021, 32'hFFFF, 1'b0, 1'b0, 32'h0);
    send_msg(0, 1'b0);
    wait_crc(lat);
    take_crc("crc16_ccitt", 32'h000029B1, 0);

    // CRC-32 with random input gaps and a stalled consumer
    do_start(5'd31, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
    send_msg(3, 1'b0);
    wait_crc(lat);
    take_crc("crc32_gaps", 32'hCBF43926, 5);

    // Back-to-back: CRC-8 with cfg/start churn during the message, then CRC-16/ARC
    do_start(5'd7, 32'h07, 32'h0, 1'b0, 1'b0, 32'h0);
    send_msg(0, 1'b1);
    wait_crc(lat);
    take_crc("b2b_crc8", 32'h000000F4, 0);
    do_start(5'd15, 32'h8005, 32'h0, 1'b1, 1'b1, 32'h0);
    send_msg(0, 1'b0);
    wait_crc(lat);
    take_crc("b2b_crc16_arc", 32'h0000BB3D, 0);

    // Reset while shifting byte 3 of a CRC-32 message
    do_start(5'd31, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
    send_byte(msg[0], 1'b0, 0, 1'b0);
    send_byte(msg[1], 1'b0, 0, 1'b0);
    send_byte(msg[2], 1'b0, 0, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_crc_valid", {31'b0, crc_valid}, 32'd0);
    check("midrst_crc_out", crc_out, 32'd0);
    step();
    do_start(5'd31, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
    send_msg(0, 1'b0);
    wait_crc(lat);
    take_crc("crc32_after_rst", 32'hCBF43926, 0);

    // Single-byte CRC-8 of 0x00, init 0xFF, with in_valid held high through SHIFT
    do_start(5'd7, 32'h07, 32'hFF, 1'b0, 1'b0, 32'h0);
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
    step();
    in_data = 8'hAA; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("shift_in_ready_low", {31'b0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    wait_crc(lat);
    take_crc("crc8_single", 32'h000000F3, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
